// File: rtl/rf_writeback_arbiter_pkg.sv
// rf_wb_pkg: shared widths and the queued write-back entry type
package rf_wb_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;
  typedef struct packed {
    logic              live;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/rf_writeback_arbiter_if.sv
// rf_writeback_arbiter_if: ALU/slow-path sources and the RF write port
interface rf_writeback_arbiter_if #(parameter int DEPTH = 4);
  import rf_wb_pkg::*;
  localparam int CW = $clog2(DEPTH) + 1;
  logic                alu_valid;
  logic [ADDR_W-1:0]   alu_rd;
  logic [DATA_W-1:0]   alu_data;
  logic                lsu_valid;
  logic                lsu_ready;
  logic [ADDR_W-1:0]   lsu_rd;
  logic [DATA_W-1:0]   lsu_data;
  logic                RegWrite;
  logic [ADDR_W-1:0]   RD_Address;
  logic [DATA_W-1:0]   RDdata;
  logic [CW-1:0]       q_count;
  logic [NUM_REGS-1:0] pending_mask;
  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready, RegWrite, RD_Address, RDdata, q_count, pending_mask
  );
  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output lsu_ready, RegWrite, RD_Address, RDdata, q_count, pending_mask
  );
endinterface

// File: rtl/rf_writeback_arbiter_wb_fifo.sv
// wb_fifo: circular buffer of write-back entries with per-register squash
module wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  wb_entry_t             push_entry_i,
  input  logic                  pop_i,
  input  logic                  clr_en_i,
  input  logic [ADDR_W-1:0]     clr_rd_i,
  output logic [$clog2(DEPTH):0] count_o,
  output wb_entry_t             head_o,
  output logic [DEPTH-1:0]      live_o,
  output logic [ADDR_W-1:0]     rd_o [DEPTH]
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  wb_entry_t         mem_q [DEPTH];
  wb_entry_t         mem_d [DEPTH];
  logic [PW-1:0]     wr_q, rd_q;
  logic [CW-1:0]     cnt_q;
  // Free slots always have live=0 (cleared on pop), so live alone marks pending writes
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++)
      if (clr_en_i && mem_q[i].rd == clr_rd_i) mem_d[i].live = 1'b0;
    if (pop_i) mem_d[rd_q].live = 1'b0;
    if (push_i) mem_d[wr_q] = push_entry_i;
  end
  // Storage, wrapping pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_q + PW'(push_i);
      rd_q  <= rd_q + PW'(pop_i);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end
  // Per-slot view for hazard mask generation
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      live_o[i] = mem_q[i].live;
      rd_o[i]   = mem_q[i].rd;
    end
  end
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];
endmodule

// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter: merges ALU and slow-path results onto the RF write port
module rf_writeback_arbiter
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  rf_writeback_arbiter_if.slave  bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [CW-1:0]       count;
  wb_entry_t           head, push_entry;
  logic [DEPTH-1:0]    live_vec;
  logic [ADDR_W-1:0]   rd_vec [DEPTH];
  logic                alu_w, xfer, empty, pop, emit_head, bypass, push;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [NUM_REGS-1:0] pend;
  // Readiness looks at registered occupancy only, so a full queue never accepts
  assign bus.lsu_ready = rst_n & (count < CW'(DEPTH));
  // Priority: ALU, then queue head, then bypass of a lone slow write into an empty queue
  always_comb begin
    alu_w      = bus.alu_valid & (bus.alu_rd != REG_ZERO);
    xfer       = bus.lsu_valid & bus.lsu_ready;
    empty      = (count == '0);
    pop        = !alu_w & !empty;
    emit_head  = pop & head.live;
    bypass     = !alu_w & empty & xfer & (bus.lsu_rd != REG_ZERO);
    push       = xfer & (bus.lsu_rd != REG_ZERO) & !bypass & !(alu_w & (bus.lsu_rd == bus.alu_rd));
    push_entry = '{live: 1'b1, rd: bus.lsu_rd, data: bus.lsu_data};
    we_d       = alu_w | emit_head | bypass;
    addr_d     = alu_w ? bus.alu_rd : emit_head ? head.rd : bypass ? bus.lsu_rd : addr_q;
    data_d     = alu_w ? bus.alu_data : emit_head ? head.data : bypass ? bus.lsu_data : data_q;
  end
  // Registered RF write port; address/data hold when no write is emitted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end
  // Hazard mask: registers targeted by live queued entries
  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++)
      if (live_vec[i]) pend[rd_vec[i]] = 1'b1;
  end
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .clr_en_i     (alu_w),
    .clr_rd_i     (bus.alu_rd),
    .count_o      (count),
    .head_o       (head),
    .live_o       (live_vec),
    .rd_o         (rd_vec)
  );
  assign bus.RegWrite     = we_q;
  assign bus.RD_Address   = addr_q;
  assign bus.RDdata       = data_q;
  assign bus.q_count      = count;
  assign bus.pending_mask = pend;
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// tb_rf_writeback_arbiter: queue-model scoreboard plus directed literal checks
module tb_rf_writeback_arbiter;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  rf_writeback_arbiter_if #(.DEPTH(DEPTH)) bus ();
  rf_writeback_arbiter #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    bit          live;
    logic [4:0]  rd;
    logic [31:0] data;
  } ment_t;
  ment_t       mq[$];
  ment_t       e;
  logic        m_we = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  logic [31:0] rf_m [32];
  logic [31:0] exp_pm;
  bit          aw, xf, byp;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask
  // Reference: a plain queue of pending writes, one decision per clock
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_we = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      aw  = bus.alu_valid && bus.alu_rd != 0;
      xf  = bus.lsu_valid && mq.size() < DEPTH;
      byp = 1'b0;
      if (aw) foreach (mq[i]) if (mq[i].rd == bus.alu_rd) mq[i].live = 1'b0;
      m_we = 1'b0;
      if (aw) begin
        m_we = 1'b1; m_addr = bus.alu_rd; m_data = bus.alu_data;
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        if (e.live) begin m_we = 1'b1; m_addr = e.rd; m_data = e.data; end
      end else if (xf && bus.lsu_rd != 0) begin
        byp = 1'b1; m_we = 1'b1; m_addr = bus.lsu_rd; m_data = bus.lsu_data;
      end
      if (xf && bus.lsu_rd != 0 && !byp && !(aw && bus.lsu_rd == bus.alu_rd))
        mq.push_back('{1'b1, bus.lsu_rd, bus.lsu_data});
      if (m_we) rf_m[m_addr] = m_data;
    end
  end
  // Every-cycle comparison of all outputs against the reference
  always @(posedge clk) begin
    #1;
    exp_pm = '0;
    foreach (mq[i]) if (mq[i].live) exp_pm[mq[i].rd] = 1'b1;
    chk("m_we",   64'(bus.RegWrite), 64'(m_we));
    chk("m_addr", 64'(bus.RD_Address), 64'(m_addr));
    chk("m_data", 64'(bus.RDdata), 64'(m_data));
    chk("m_cnt",  64'(bus.q_count), 64'(mq.size()));
    chk("m_pend", 64'(bus.pending_mask), 64'(exp_pm));
    chk("m_rdy",  64'(bus.lsu_ready), 64'(rst_n && mq.size() < DEPTH));
  end
  task automatic cyc(bit av, logic [4:0] ar, logic [31:0] ad, bit lv, logic [4:0] lr, logic [31:0] ld);
    bus.alu_valid = av; bus.alu_rd = ar; bus.alu_data = ad;
    bus.lsu_valid = lv; bus.lsu_rd = lr; bus.lsu_data = ld;
    @(negedge clk);
  endtask
  initial begin
    for (int i = 0; i < 32; i++) rf_m[i] = '0;
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.lsu_valid = 0; bus.lsu_rd = 0; bus.lsu_data = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    chk("rst_we", 64'(bus.RegWrite), 0);
    chk("rst_cnt", 64'(bus.q_count), 0);
    chk("rst_rdy", 64'(bus.lsu_ready), 1);
    chk("rst_pend", 64'(bus.pending_mask), 0);
    cyc(0, 0, 0, 1, 7, 32'h1234);
    chk("byp_we", 64'(bus.RegWrite), 1);
    chk("byp_addr", 64'(bus.RD_Address), 7);
    chk("byp_data", 64'(bus.RDdata), 32'h1234);
    chk("byp_cnt", 64'(bus.q_count), 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 3, 32'h300 + i, 1, 5'(9 + i), 32'h909 + i);
      if (i == 3) begin
        chk("full_cnt", 64'(bus.q_count), 4);
        chk("full_rdy", 64'(bus.lsu_ready), 0);
        chk("full_pend", 64'(bus.pending_mask), 32'h1E00);
      end
    end
    chk("full_cnt5", 64'(bus.q_count), 4);
    chk("alu_data5", 64'(bus.RDdata), 32'h304);
    cyc(0, 0, 0, 1, 13, 32'h90D);
    chk("drain9", 64'(bus.RD_Address), 9);
    chk("drain9_d", 64'(bus.RDdata), 32'h909);
    cyc(0, 0, 0, 1, 13, 32'h90D);
    chk("drain10", 64'(bus.RD_Address), 10);
    chk("refill_cnt", 64'(bus.q_count), 3);
    for (int j = 11; j <= 13; j++) begin
      cyc(0, 0, 0, 0, 0, 0);
      chk("drain_we", 64'(bus.RegWrite), 1);
      chk("drain_addr", 64'(bus.RD_Address), 64'(j));
      chk("drain_data", 64'(bus.RDdata), 64'(32'h900 + j));
    end
    cyc(0, 0, 0, 0, 0, 0);
    chk("empty_cnt", 64'(bus.q_count), 0);
    cyc(1, 6, 32'h66, 1, 5, 32'hAA);
    chk("sq_pend", 64'(bus.pending_mask), 32'h20);
    cyc(1, 5, 32'hBB, 0, 0, 0);
    chk("sq_addr", 64'(bus.RD_Address), 5);
    chk("sq_data", 64'(bus.RDdata), 32'hBB);
    chk("sq_pend0", 64'(bus.pending_mask), 0);
    chk("sq_cnt", 64'(bus.q_count), 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("sq_pop_we", 64'(bus.RegWrite), 0);
    chk("sq_hold", 64'(bus.RDdata), 32'hBB);
    chk("sq_cnt0", 64'(bus.q_count), 0);
    chk("model_r5", 64'(rf_m[5]), 32'hBB);
    chk("same_rdy", 64'(bus.lsu_ready), 1);
    cyc(1, 8, 32'h1, 1, 8, 32'h2);
    chk("same_addr", 64'(bus.RD_Address), 8);
    chk("same_data", 64'(bus.RDdata), 1);
    chk("same_cnt", 64'(bus.q_count), 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("same_after", 64'(bus.RegWrite), 0);
    chk("model_r8", 64'(rf_m[8]), 1);
    cyc(0, 0, 0, 1, 0, 32'h55);
    chk("lsu_r0_we", 64'(bus.RegWrite), 0);
    chk("lsu_r0_cnt", 64'(bus.q_count), 0);
    cyc(1, 0, 32'h77, 0, 0, 0);
    chk("alu_r0_we", 64'(bus.RegWrite), 0);
    cyc(1, 6, 32'h66, 1, 14, 32'hE);
    cyc(1, 0, 32'h77, 0, 0, 0);
    chk("r0_drain_we", 64'(bus.RegWrite), 1);
    chk("r0_drain_addr", 64'(bus.RD_Address), 14);
    for (int k = 0; k < 3; k++) cyc(1, 1, 32'h100 + k, 1, 5'(20 + k), 32'h920 + k);
    chk("pre_rst_cnt", 64'(bus.q_count), 3);
    bus.alu_valid = 0; bus.lsu_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cnt", 64'(bus.q_count), 0);
    chk("arst_we", 64'(bus.RegWrite), 0);
    chk("arst_rdy", 64'(bus.lsu_ready), 0);
    chk("arst_pend", 64'(bus.pending_mask), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 0, 0, 0);
      chk("post_rst_we", 64'(bus.RegWrite), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
